// File: rtl/counter_pkg.sv
// counter_pkg: direction/mode constants and clamped-load helper shared by the modulo counter.
package counter_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  // Values outside the count range are pinned to the top of the range.
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] modulus);
    return (value >= modulus) ? modulus - 32'd1 : value;
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: gates count steps to one per (prescale+1) enabled cycles.
module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_hit;
  assign w_hit = (r_cnt == prescale);
  assign step  = enable & w_hit;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (enable) r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/modulo_updown_counter.sv
// modulo_updown_counter: up/down modulo counter with load, clear, wrap/saturate, tc and sticky overflow.
// Optional prescaler gate enabled by defining MODULO_COUNTER_PRESCALE_EN.
module modulo_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 16,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  saturate,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
`ifdef MODULO_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  overflow
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || PRESCALE_W < 1) begin : g_bad_params
    $error("modulo_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_overflow;
  logic             w_step;
  logic             w_up;
  logic             w_sat;
  logic             w_end;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;

`ifdef MODULO_COUNTER_PRESCALE_EN
  logic w_gate;
  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable & ~clear & ~load),
    .clr      (clear | load),
    .prescale (prescale),
    .step     (w_gate)
  );
  assign w_step = enable & w_gate;
`else
  assign w_step = enable;
`endif

  assign w_up   = (up == DIR_UP);
  assign w_sat  = (saturate == MODE_SAT);
  assign w_load = WIDTH'(clamp_load(32'(load_value), 32'(MODULUS)));

  // Range ends are explicit compares so non-power-of-two moduli wrap correctly.
  always_comb begin
    w_end  = w_up ? (r_count == MAX) : (r_count == '0);
    w_next = w_end ? (w_sat ? r_count : (w_up ? '0 : MAX))
                   : (w_up ? r_count + 1'b1 : r_count - 1'b1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_overflow <= 1'b0;
    end else if (load) begin
      r_count <= w_load;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count    <= w_next;
      r_tc       <= w_end;
      r_overflow <= r_overflow | w_end;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign overflow = r_overflow;
endmodule
